// File: rtl/fifo2stream.sv
// fifo2stream: drains a 1-cycle-latency FIFO read port (fifo_ren/fifo_rdata/fifo_rempty)
// into a registered valid/ready stream. It uses a two-entry buffer (head + skid) so that
// one word per cycle is sustained. m_ready only reaches fifo_ren through pop.
// Optional build macro FIFO2STREAM_CNT_EN adds a 32-bit beat counter output (beat_cnt).
//
// Handshake: a word transfers on a rising clk edge where m_valid=1 and m_ready=1.
// Once m_valid is raised, m_valid and m_data hold until that transfer happens.
// A FIFO read is accepted on an edge where fifo_ren=1 and fifo_rempty=0. Its data
// appears on fifo_rdata during the following cycle.
module fifo2stream #(
  parameter int FIFO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  output logic                  fifo_ren,
  input  logic [FIFO_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_rempty,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready
`ifdef FIFO2STREAM_CNT_EN
  ,
  output logic [31:0]           beat_cnt
`endif
);

  // run_q holds reads off while reset is asserted. This keeps fifo_ren low during reset
  // without a combinational path from arstn.
  logic                  run_q, run_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] skid_q, skid_d;

  logic                  pop;
  logic [2:0]            occ_sum;
  logic [1:0]            occ_rem;

  // Occupancy bookkeeping and read request. Only registered state and fifo_rempty are
  // used, plus m_ready through pop.
  always_comb begin
    pop      = (occ_q != 2'd0) & m_ready;
    occ_sum  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    occ_rem  = occ_q - {1'b0, pop};
    fifo_ren = run_q & ~fifo_rempty & (occ_sum < 3'd2);
  end

  // Next-state logic. Remove the popped word first, then append the arriving word
  // behind whatever is left.
  always_comb begin
    run_d      = 1'b1;
    inflight_d = fifo_ren;
    occ_d      = occ_sum[1:0];
    head_d     = head_q;
    skid_d     = skid_q;
    if (pop && (occ_q == 2'd2)) begin
      head_d = skid_q;
    end
    if (inflight_q) begin
      if (occ_rem == 2'd0) begin
        head_d = fifo_rdata;
      end else begin
        skid_d = fifo_rdata;
      end
    end
  end

  // State registers. Reset drops any word that is still in flight.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      run_q      <= run_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = head_q;

  // The read throttle guarantees the buffer can never hold more than two words.
  a_no_overflow: assert property (@(posedge clk) disable iff (!arstn) occ_sum <= 3'd2);
  // A read must never be requested while the FIFO is empty.
  a_no_empty_read: assert property (@(posedge clk) disable iff (!arstn) !(fifo_ren && fifo_rempty));

`ifdef FIFO2STREAM_CNT_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;

  // Count completed output transfers. The counter wraps naturally at 2^32.
  always_comb begin
    beat_cnt_d = beat_cnt_q + {31'd0, pop};
  end

  // Beat counter register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      beat_cnt_q <= 32'd0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule
